dut_sched: RTL and testbench

- Host-side command scheduler in front of the DUT interface.
- Pops a unified host command stream and routes each entry:
  - test vectors go to STIM_FIFO;
  - configuration commands (mux setup, trigger mask) go to DI_FIFO.
- Tracks vectors in flight (written to STIM_FIFO but with no result yet in RES_FIFO).
- Holds every configuration command and end-of-test barrier until the pipeline has drained, so configuration never changes under a running vector.

---
 rtl/dut_sched.sv | 132 +++++++++++++
 tb/tb_dut_sched.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dut_sched.sv
// Host command scheduler: routes vectors to STIM_FIFO and config/END to DI_FIFO, holding config until in-flight vectors drain.
// Latency: host pop at N -> stimulus write at N+2 at the earliest; writes stall on full FIFOs or when MAX_OUTSTANDING vectors are in flight.
module dut_sched #(
  parameter int STF_WIDTH       = 24,
  parameter int CYCLE_RANGE     = 5,
  parameter int REQ_WIDTH       = 3,
  parameter int CMD_WIDTH       = 5,
  parameter int MAX_OUTSTANDING = 16,
  parameter int CNT_WIDTH       = 5,
  parameter int HW              = REQ_WIDTH + CMD_WIDTH + STF_WIDTH + CYCLE_RANGE + 1,
  parameter int DIF_WIDTH       = REQ_WIDTH + CMD_WIDTH + STF_WIDTH
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               enable,
  input  logic [HW-1:0]                      hfifo_data,
  output logic                               hfifo_rdreq,
  input  logic                               hfifo_rdempty,
  output logic [STF_WIDTH+CYCLE_RANGE:0]     sfifo_data,
  output logic                               sfifo_wrreq,
  input  logic                               sfifo_wrfull,
  output logic [DIF_WIDTH-1:0]               dififo_data,
  output logic                               dififo_wrreq,
  input  logic                               dififo_wrfull,
  input  logic                               rfifo_wrreq_mon,
  output logic [CNT_WIDTH-1:0]               outstanding,
  output logic                               busy,
  output logic                               done,
  output logic [1:0]                         err
);

  localparam int PW = STF_WIDTH + CYCLE_RANGE + 1;

  localparam logic [CMD_WIDTH-1:0] CMD_VECTOR = CMD_WIDTH'(0);
  localparam logic [CMD_WIDTH-1:0] CMD_SETUP  = CMD_WIDTH'(1);
  localparam logic [CMD_WIDTH-1:0] CMD_TRG    = CMD_WIDTH'(2);
  localparam logic [CMD_WIDTH-1:0] CMD_END    = CMD_WIDTH'(31);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_ISSUE_VEC,
    S_DRAIN,
    S_ISSUE_CFG,
    S_DONE
  } state_t;

  state_t                 state;
  logic [REQ_WIDTH-1:0]   hold_req;
  logic [CMD_WIDTH-1:0]   hold_cmd;
  logic [PW-1:0]          hold_pay;
  logic                   end_flag;

  logic [REQ_WIDTH-1:0]   in_req;
  logic [CMD_WIDTH-1:0]   in_cmd;
  logic [PW-1:0]          in_pay;
  logic                   vec_room;

  assign in_req = hfifo_data[HW-1 -: REQ_WIDTH];
  assign in_cmd = hfifo_data[PW +: CMD_WIDTH];
  assign in_pay = hfifo_data[PW-1:0];

  // Strobes are gated by reset_n so nothing is written or popped while reset is held.
  assign vec_room     = (outstanding < CNT_WIDTH'(MAX_OUTSTANDING));
  assign hfifo_rdreq  = reset_n & (state == S_IDLE) & enable & ~hfifo_rdempty;
  assign sfifo_wrreq  = reset_n & (state == S_ISSUE_VEC) & ~sfifo_wrfull & vec_room;
  assign dififo_wrreq = reset_n & (state == S_ISSUE_CFG) & ~dififo_wrfull;

  assign sfifo_data  = hold_pay;
  assign dififo_data = {hold_req, hold_cmd, hold_pay[STF_WIDTH-1:0]};
  assign done        = (state == S_DONE);
  assign busy        = (state != S_IDLE) | (outstanding != '0);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      hold_req    <= '0;
      hold_cmd    <= '0;
      hold_pay    <= '0;
      end_flag    <= 1'b0;
      outstanding <= '0;
      err         <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (hfifo_rdreq) state <= S_DECODE;
        end
        S_DECODE: begin
          hold_req <= in_req;
          hold_cmd <= in_cmd;
          hold_pay <= in_pay;
          if (in_cmd == CMD_VECTOR) begin
            state <= S_ISSUE_VEC;
          end else if (in_cmd == CMD_SETUP || in_cmd == CMD_TRG) begin
            state <= S_DRAIN;
          end else if (in_cmd == CMD_END) begin
            end_flag <= 1'b1;
            state    <= S_DRAIN;
          end else begin
            err[0] <= 1'b1;
            state  <= S_IDLE;
          end
        end
        S_ISSUE_VEC: begin
          if (sfifo_wrreq) state <= S_IDLE;
        end
        S_DRAIN: begin
          if (outstanding == '0) state <= end_flag ? S_DONE : S_ISSUE_CFG;
        end
        S_ISSUE_CFG: begin
          if (dififo_wrreq) state <= S_IDLE;
        end
        S_DONE: begin
          end_flag <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // A result arriving with nothing in flight is a protocol error; the count saturates at zero.
      case ({sfifo_wrreq, rfifo_wrreq_mon})
        2'b10: outstanding <= outstanding + CNT_WIDTH'(1);
        2'b01: begin
          if (outstanding == '0) err[1] <= 1'b1;
          else                   outstanding <= outstanding - CNT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dut_sched.sv
// Directed bench for dut_sched: a routing table plus hand-timed sequences for barriers, backpressure and reset.
module tb_dut_sched;
  localparam int PW = 30;
  localparam int HW = 38;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset_n, enable;
  logic [HW-1:0] hfifo_data;
  logic          hfifo_rdreq, hfifo_rdempty;
  logic [PW-1:0] sfifo_data;
  logic          sfifo_wrreq, sfifo_wrfull;
  logic [DW-1:0] dififo_data;
  logic          dififo_wrreq, dififo_wrfull, rfifo_wrreq_mon;
  logic [4:0]    outstanding;
  logic          busy, done;
  logic [1:0]    err;

  int checks = 0;
  int failures = 0;
  int s_cnt = 0, d_cnt = 0, done_cnt = 0;
  logic [PW-1:0] s_last = '0;
  logic [DW-1:0] d_last = '0;
  logic          pop_pend = 1'b0;
  logic [HW-1:0] hq[$];

  always #5 clock = ~clock;

  dut_sched dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .hfifo_data(hfifo_data), .hfifo_rdreq(hfifo_rdreq), .hfifo_rdempty(hfifo_rdempty),
    .sfifo_data(sfifo_data), .sfifo_wrreq(sfifo_wrreq), .sfifo_wrfull(sfifo_wrfull),
    .dififo_data(dififo_data), .dififo_wrreq(dififo_wrreq), .dififo_wrfull(dififo_wrfull),
    .rfifo_wrreq_mon(rfifo_wrreq_mon), .outstanding(outstanding),
    .busy(busy), .done(done), .err(err)
  );

  // Mid-cycle observer: records writes/done and whether the host FIFO is popped this cycle.
  always @(negedge clock) begin
    pop_pend = hfifo_rdreq;
    if (sfifo_wrreq)  begin s_cnt++; s_last = sfifo_data; end
    if (dififo_wrreq) begin d_cnt++; d_last = dififo_data; end
    if (done) done_cnt++;
  end

  // Advance one cycle; the host FIFO model presents popped data the cycle after rdreq.
  task automatic cyc();
    @(posedge clock);
    #1;
    if (pop_pend && hq.size() > 0) hfifo_data = hq.pop_front();
    hfifo_rdempty = (hq.size() == 0);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  function automatic logic [HW-1:0] mk(input logic [2:0] r, input logic [4:0] c, input logic [PW-1:0] p);
    return {r, c, p};
  endfunction

  typedef struct {
    logic [2:0]    req;
    logic [4:0]    cmd;
    logic [PW-1:0] pay;
    int            es;
    int            ed;
    int            edn;
    logic [31:0]   dat;
    logic [4:0]    out;
    logic [1:0]    er;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int s0, d0, n0;
    tbl[0] = '{3'h2, 5'h01, 30'h0000003,  0, 1, 0, 32'h41000003, 5'd0, 2'b00};
    tbl[1] = '{3'h5, 5'h02, 30'h3F123456, 0, 1, 0, 32'hA2123456, 5'd0, 2'b00};
    tbl[2] = '{3'h0, 5'h1F, 30'h0,        0, 0, 1, 32'h0,        5'd0, 2'b00};
    tbl[3] = '{3'h1, 5'h07, 30'h15,       0, 0, 0, 32'h0,        5'd0, 2'b01};
    tbl[4] = '{3'h0, 5'h00, 30'h00ABCDE1, 1, 0, 0, 32'h00ABCDE1, 5'd1, 2'b01};
    tbl[5] = '{3'h7, 5'h00, 30'h3FFFFFFF, 1, 0, 0, 32'h3FFFFFFF, 5'd2, 2'b01};
    tbl[6] = '{3'h3, 5'h03, 30'h2222,     0, 0, 0, 32'h0,        5'd2, 2'b01};

    reset_n = 1'b0; enable = 1'b1; hfifo_data = '0; hfifo_rdempty = 1'b1;
    sfifo_wrfull = 1'b0; dififo_wrfull = 1'b0; rfifo_wrreq_mon = 1'b0;

    // Reset state
    cyc(); cyc(); #1;
    chk("rst_rdreq", hfifo_rdreq, 0);
    chk("rst_swr", sfifo_wrreq, 0);
    chk("rst_dwr", dififo_wrreq, 0);
    chk("rst_sdat", sfifo_data, 0);
    chk("rst_ddat", dififo_data, 0);
    chk("rst_out", outstanding, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    cyc();

    // Vector flow: pop at cycle 0, write at cycle 2
    hq.push_back(mk(3'h0, 5'h00, 30'h00ABCDE1));
    cyc(); #1;
    chk("vf_rdreq_c0", hfifo_rdreq, 1);
    cyc(); #1;
    chk("vf_swr_c1", sfifo_wrreq, 0);
    cyc(); #1;
    chk("vf_swr_c2", sfifo_wrreq, 1);
    chk("vf_sdat_c2", sfifo_data, 30'h00ABCDE1);
    cyc(); #1;
    chk("vf_out", outstanding, 1);
    rfifo_wrreq_mon = 1'b1;
    cyc();
    rfifo_wrreq_mon = 1'b0; #1;
    chk("vf_out_ret", outstanding, 0);

    // Routing table
    for (int i = 0; i < 7; i++) begin
      s0 = s_cnt; d0 = d_cnt; n0 = done_cnt;
      hq.push_back(mk(tbl[i].req, tbl[i].cmd, tbl[i].pay));
      repeat (6) cyc();
      #1;
      chk($sformatf("tbl%0d_swr", i), s_cnt - s0, tbl[i].es);
      chk($sformatf("tbl%0d_dwr", i), d_cnt - d0, tbl[i].ed);
      chk($sformatf("tbl%0d_done", i), done_cnt - n0, tbl[i].edn);
      if (tbl[i].es > 0) chk($sformatf("tbl%0d_sdat", i), s_last, tbl[i].dat);
      if (tbl[i].ed > 0) chk($sformatf("tbl%0d_ddat", i), d_last, tbl[i].dat);
      chk($sformatf("tbl%0d_out", i), outstanding, tbl[i].out);
      chk($sformatf("tbl%0d_err", i), err, tbl[i].er);
    end

    // Reset in ISSUE_CFG with DI_FIFO full
    do_reset();
    dififo_wrfull = 1'b1;
    d0 = d_cnt;
    hq.push_back(mk(3'h1, 5'h01, 30'h55));
    repeat (4) cyc(); #1;
    chk("rcfg_busy_pre", busy, 1);
    chk("rcfg_dwr_pre", dififo_wrreq, 0);
    reset_n = 1'b0;
    cyc(); #1;
    chk("rcfg_busy", busy, 0);
    chk("rcfg_ddat", dififo_data, 0);
    chk("rcfg_dwr", dififo_wrreq, 0);
    chk("rcfg_err", err, 0);
    reset_n = 1'b1;
    dififo_wrfull = 1'b0;
    repeat (5) cyc(); #1;
    chk("rcfg_nowrite", d_cnt - d0, 0);

    // Underflow
    rfifo_wrreq_mon = 1'b1;
    cyc();
    rfifo_wrreq_mon = 1'b0; #1;
    chk("uf_out", outstanding, 0);
    chk("uf_err", err, 2'b10);

    // Config barrier behind 3 vectors
    s0 = s_cnt; d0 = d_cnt;
    for (int i = 0; i < 3; i++) hq.push_back(mk(3'h0, 5'h00, PW'(30'h100 + i)));
    hq.push_back(mk(3'h4, 5'h01, 30'h0000003));
    repeat (20) cyc(); #1;
    chk("bar_swr", s_cnt - s0, 3);
    chk("bar_out3", outstanding, 3);
    rfifo_wrreq_mon = 1'b1;
    cyc(); cyc();
    rfifo_wrreq_mon = 1'b0;
    repeat (3) cyc(); #1;
    chk("bar_out1", outstanding, 1);
    chk("bar_hold2", d_cnt - d0, 0);
    rfifo_wrreq_mon = 1'b1; #1;
    chk("bar_dwr_k", dififo_wrreq, 0);
    cyc();
    rfifo_wrreq_mon = 1'b0; #1;
    chk("bar_dwr_k1", dififo_wrreq, 0);
    chk("bar_out0", outstanding, 0);
    cyc(); #1;
    chk("bar_dwr_k2", dififo_wrreq, 1);
    chk("bar_ddat", dififo_data, 32'h81000003);
    cyc();

    // Backpressure: STIM_FIFO full for 5 cycles in ISSUE_VEC
    s0 = s_cnt;
    sfifo_wrfull = 1'b1;
    hq.push_back(mk(3'h0, 5'h00, 30'h0C0FFEE));
    repeat (7) cyc(); #1;
    chk("bp1_nowrite", s_cnt - s0, 0);
    cyc();
    sfifo_wrfull = 1'b0; #1;
    chk("bp1_swr", sfifo_wrreq, 1);
    chk("bp1_sdat", sfifo_data, 30'h0C0FFEE);
    cyc();
    rfifo_wrreq_mon = 1'b1;
    cyc();
    rfifo_wrreq_mon = 1'b0;

    // Simultaneous increment and decrement at outstanding 2
    hq.push_back(mk(3'h0, 5'h00, 30'h1));
    hq.push_back(mk(3'h0, 5'h00, 30'h2));
    repeat (8) cyc(); #1;
    chk("sim_out2", outstanding, 2);
    hq.push_back(mk(3'h0, 5'h00, 30'h3));
    cyc(); cyc(); cyc();
    rfifo_wrreq_mon = 1'b1; #1;
    chk("sim_swr", sfifo_wrreq, 1);
    cyc();
    rfifo_wrreq_mon = 1'b0; #1;
    chk("sim_out", outstanding, 2);

    // Backpressure: 16 vectors in flight
    for (int i = 0; i < 14; i++) hq.push_back(mk(3'h0, 5'h00, PW'(30'h200 + i)));
    repeat (46) cyc(); #1;
    chk("bp2_out16", outstanding, 16);
    s0 = s_cnt;
    hq.push_back(mk(3'h0, 5'h00, 30'h3ABCDE));
    repeat (6) cyc(); #1;
    chk("bp2_stall", s_cnt - s0, 0);
    rfifo_wrreq_mon = 1'b1; #1;
    chk("bp2_swr_k", sfifo_wrreq, 0);
    cyc();
    rfifo_wrreq_mon = 1'b0; #1;
    chk("bp2_out15", outstanding, 15);
    chk("bp2_swr_k1", sfifo_wrreq, 1);
    cyc(); #1;
    chk("bp2_out_back", outstanding, 16);
    rfifo_wrreq_mon = 1'b1;
    repeat (16) cyc();
    rfifo_wrreq_mon = 1'b0; #1;
    chk("bp2_drained", outstanding, 0);

    // Unknown command, then END after 2 vectors
    do_reset();
    s0 = s_cnt; d0 = d_cnt;
    hq.push_back(mk(3'h0, 5'h07, 30'h77));
    repeat (6) cyc(); #1;
    chk("unk_err", err, 2'b01);
    chk("unk_writes", (s_cnt - s0) + (d_cnt - d0), 0);
    n0 = done_cnt;
    hq.push_back(mk(3'h0, 5'h00, 30'h11));
    hq.push_back(mk(3'h0, 5'h00, 30'h22));
    hq.push_back(mk(3'h0, 5'h1F, 30'h0));
    repeat (12) cyc(); #1;
    chk("end_wait", done_cnt - n0, 0);
    chk("end_out2", outstanding, 2);
    rfifo_wrreq_mon = 1'b1;
    cyc(); cyc();
    rfifo_wrreq_mon = 1'b0; #1;
    chk("end_out0", outstanding, 0);
    chk("end_done_k", done, 0);
    cyc(); #1;
    chk("end_done_k1", done, 1);
    cyc(); #1;
    chk("end_done_k2", done, 0);
    repeat (3) cyc(); #1;
    chk("end_once", done_cnt - n0, 1);
    chk("end_busy", busy, 0);

    // enable low blocks pops
    enable = 1'b0;
    s0 = s_cnt;
    hq.push_back(mk(3'h0, 5'h00, 30'h99));
    repeat (5) cyc(); #1;
    chk("en_rdreq", hfifo_rdreq, 0);
    chk("en_nowrite", s_cnt - s0, 0);
    enable = 1'b1;
    repeat (4) cyc(); #1;
    chk("en_write", s_cnt - s0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
